// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for "d op d op ... =" character streams.
// Single-digit operands, '+' and '*' with '*' binding tighter, '=' ends an
// expression. One character per cycle, results registered with 1-cycle latency.
//
// Handshake: the stream has no backpressure. A character on in is consumed on
// every rising edge where in_valid is high and clr is high. When in_valid is low
// all state holds, except that done returns to 0 and a pending err clears.
module expr_eval #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         ok,
  output logic         err,
  output logic         done,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_NUM = 2'd0,
    S_OP  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] prod_q, prod_d;
  logic [W-1:0] result_q, result_d;
  logic         ok_q, ok_d;
  logic         err_q, err_d;
  logic         done_q, done_d;

  logic         is_digit;
  logic         is_plus;
  logic         is_mul;
  logic         is_eq;
  logic [W-1:0] digit_w;
  logic [W-1:0] prod_x_d;

  // Character classification and the pending term multiplied by the digit.
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_plus  = (in == 8'h2B);
    is_mul   = (in == 8'h2A);
    is_eq    = (in == 8'h3D);
    digit_w  = W'(in - 8'h30);
    prod_x_d = prod_q * digit_w;
  end

  // Next-state and output decisions; every register holds unless a rule fires.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    prod_d   = prod_q;
    result_d = result_q;
    ok_d     = ok_q;
    // err stays up for the done cycle of an erroneous expression, then drops.
    err_d    = done_q ? 1'b0 : err_q;
    done_d   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        S_NUM: begin
          if (is_digit) begin
            prod_d   = prod_x_d;
            result_d = sum_q + prod_x_d;
            ok_d     = 1'b1;
            state_d  = S_OP;
          end else begin
            err_d   = 1'b1;
            ok_d    = 1'b0;
            state_d = S_ERR;
          end
        end
        S_OP: begin
          if (is_mul) begin
            ok_d    = 1'b0;
            state_d = S_NUM;
          end else if (is_plus) begin
            sum_d   = sum_q + prod_q;
            prod_d  = {{(W-1){1'b0}}, 1'b1};
            ok_d    = 1'b0;
            state_d = S_NUM;
          end else if (is_eq) begin
            done_d  = 1'b1;
            sum_d   = '0;
            prod_d  = {{(W-1){1'b0}}, 1'b1};
            ok_d    = 1'b0;
            state_d = S_NUM;
          end else begin
            err_d   = 1'b1;
            ok_d    = 1'b0;
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (is_eq) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            sum_d   = '0;
            prod_d  = {{(W-1){1'b0}}, 1'b1};
            ok_d    = 1'b0;
            state_d = S_NUM;
          end
        end
        default: begin
          state_d = S_NUM;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= S_NUM;
      sum_q    <= '0;
      prod_q   <= {{(W-1){1'b0}}, 1'b1};
      result_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign result      = result_q;
  assign ok          = ok_q;
  assign err         = err_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_expr_eval.sv
// Testbench for expr_eval: a 32-bit and an 8-bit instance share one stimulus
// stream. A string-based reference model predicts outputs for every cycle.
module tb_expr_eval;

  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;

  logic [31:0] res32;
  logic        ok32, err32, done32;
  logic [1:0]  st32;
  logic [7:0]  res8;
  logic        ok8, err8, done8;
  logic [1:0]  st8;

  expr_eval #(.W(32)) u_dut32 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .result(res32), .ok(ok32), .err(err32), .done(done32), .dbg_state_o(st32)
  );

  expr_eval #(.W(8)) u_dut8 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_ch),
    .result(res8), .ok(ok8), .err(err8), .done(done8), .dbg_state_o(st8)
  );

  // ---------------- reference model ----------------
  // Expected record: {result[31:0], result[7:0], ok, err, done}
  logic [42:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]      expr_q[$];   // accepted characters of the current expression
  bit              m_in_err;
  longint unsigned m_result;
  bit              m_ok, m_err, m_done;

  // Value of the accepted expression: sum of products, wrapping mod 2^64.
  function automatic longint unsigned eval_expr();
    longint unsigned s = 0;
    longint unsigned p = 1;
    foreach (expr_q[i]) begin
      if (expr_q[i] == CH_PLUS) begin
        s = s + p;
        p = 1;
      end else if (expr_q[i] != CH_MUL) begin
        p = p * longint'(expr_q[i] - 8'h30);
      end
    end
    return s + p;
  endfunction

  task automatic model_step(input bit c, input bit v, input logic [7:0] ch);
    bit was_done;
    bit want_digit;
    bit is_digit;
    if (!c) begin
      expr_q.delete();
      m_in_err = 0; m_result = 0; m_ok = 0; m_err = 0; m_done = 0;
      return;
    end
    was_done = m_done;
    m_done   = 0;
    if (was_done) m_err = 0;
    if (!v) return;
    if (m_in_err) begin
      if (ch == CH_EQ) begin
        m_done = 1; m_err = 1; m_in_err = 0; m_ok = 0;
        expr_q.delete();
      end
      return;
    end
    want_digit = (expr_q.size() % 2 == 0);
    is_digit   = (ch >= 8'h30) && (ch <= 8'h39);
    if (want_digit && is_digit) begin
      expr_q.push_back(ch);
      m_result = eval_expr();
      m_ok = 1;
    end else if (!want_digit && (ch == CH_PLUS || ch == CH_MUL)) begin
      expr_q.push_back(ch);
      m_ok = 0;
    end else if (!want_digit && ch == CH_EQ) begin
      m_done = 1; m_ok = 0;
      expr_q.delete();
    end else begin
      m_in_err = 1; m_err = 1; m_ok = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit c, input bit v, input logic [7:0] ch);
    @(negedge clk);
    clr      = c;
    in_valid = v;
    in_ch    = ch;
    model_step(c, v, ch);
    exp_q.push_back({m_result[31:0], m_result[7:0], m_ok, m_err, m_done});
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, 1'b1, s[i]);
  endtask

  // Random character with occasional idle cycles, junk characters and clears.
  task automatic send_rnd(input logic [7:0] ch_in);
    logic [7:0] junk [5];
    logic [7:0] ch;
    junk = '{8'h2B, 8'h2A, 8'h3D, 8'h61, 8'h37};
    ch = ch_in;
    if ($urandom_range(0, 9) == 0) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
    if ($urandom_range(0, 15) == 0) ch = junk[$urandom_range(0, 4)];
    if ($urandom_range(0, 60) == 0) step(1'b0, 1'($urandom_range(0, 1)), ch);
    else step(1'b1, 1'b1, ch);
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [42:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({res32, ok32, err32, done32} !== {e[42:11], e[2:0]}) begin
        n_fail++;
        $display("FAIL w32 cyc=%0d got res=%0d ok=%b err=%b done=%b want res=%0d ok=%b err=%b done=%b",
                 cyc, res32, ok32, err32, done32, e[42:11], e[2], e[1], e[0]);
      end
      n_checks++;
      if ({res8, ok8, err8, done8} !== {e[10:3], e[2:0]}) begin
        n_fail++;
        $display("FAIL w8 cyc=%0d got res=%0d ok=%b err=%b done=%b want res=%0d ok=%b err=%b done=%b",
                 cyc, res8, ok8, err8, done8, e[10:3], e[2], e[1], e[0]);
      end
      n_checks++;
      if (st32 == 2'b11 || st8 == 2'b11) begin
        n_fail++;
        $display("FAIL state_enc cyc=%0d got st32=%0d st8=%0d want <3", cyc, st32, st8);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nterms;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    send_str("1+2*3=");
    send_str("1++2=");
    send_str("5=");
    send_str("1+2");
    step(1'b0, 1'b1, "3");
    send_str("4=");
    send_str("9*");
    repeat (3) step(1'b1, 1'b0, CH_PLUS);
    send_str("9=");
    send_str("9*9*9=");
    send_str("0*7+3=");
    step(1'b0, 1'b0, 8'h00);
    send_str("=");
    send_str("a=");
    send_str("=a==");
    send_str("5");
    step(1'b0, 1'b1, CH_EQ);
    send_str("7=");
    send_str("9*9*9*9*9*9*9*9*9*9*9+9=");

    for (int n = 0; n < 300; n++) begin
      nterms = $urandom_range(1, 6);
      for (int t = 0; t < nterms; t++) begin
        send_rnd(8'(8'h30 + $urandom_range(0, 9)));
        if (t < nterms - 1) send_rnd(($urandom_range(0, 1) == 1) ? CH_MUL : CH_PLUS);
      end
      send_rnd(CH_EQ);
    end

    repeat (3) step(1'b1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming arithmetic evaluator that sits directly downstream of the character-stream syntax checker. It consumes the same one-ASCII-character-per-cycle stream of single-digit operands separated by `+` and `*`, terminated by `=`. It computes the expression value with `*` binding tighter than `+`, and reports the result, well-formedness and a completion pulse per expression.

## Interface
- `W`, default 32: width of the result and internal accumulators; all arithmetic is modulo 2^W.

- `clk`  input  1  clock; all state changes on the rising edge.
- `clr`  input  1  reset, synchronous, active-low; while low at a rising edge every register takes its reset value, and this overrides `in_valid`.
- `in_valid`  input  1  `in` holds a character to consume this cycle.
- `in`  input  8  ASCII character.
- `result`  output  W  registered value of the expression so far.
- `ok`  output  1  registered; 1 when the characters consumed so far form a complete, well-formed expression (ends in a digit).
- `err`  output  1  registered; the current expression contains a syntax error.
- `done`  output  1  registered one-cycle pulse; the cycle after `=` is consumed.

## Operation
- Character classes: digit `0`..`9` (value = `in - 8'h30`), PLUS `+`, MUL `*`, EQ `=`, OTHER (anything else).
- Internal registers:
  - `sum` (W): reset 0.
  - `prod` (W): reset 1, the pending multiplicative term.
  - state: reset S_NUM.
- Reset values of outputs: `result` = 0, `ok` = 0, `err` = 0, `done` = 0.
- States:
  - S_NUM (expecting an operand):
    - digit d: `prod` <= `prod`*d; `result` <= `sum` + `prod`*d; `ok` <= 1; go to S_OP.
    - PLUS, MUL, EQ or OTHER: go to S_ERR; `err` <= 1; `ok` <= 0.
  - S_OP (expecting an operator):
    - MUL: `ok` <= 0; go to S_NUM.
    - PLUS: `sum` <= `sum` + `prod`; `prod` <= 1; `ok` <= 0; go to S_NUM.
    - EQ: `done` <= 1; `result` holds; restart (`sum` <= 0, `prod` <= 1, `ok` <= 0); go to S_NUM.
    - digit or OTHER: go to S_ERR; `err` <= 1; `ok` <= 0.
  - S_ERR:
    - Every character except EQ is ignored.
    - EQ: `done` <= 1 with `err` still 1 in the same cycle; restart as above; go to S_NUM.
    - `err` clears on the cycle after `done`.
- Operation results are reported on the same clock edge they are decided, not one character later.
- `in_valid` = 0: all registers hold; `done` returns to 0.
- `result` keeps its last value across `=` and restart until the next digit is accepted; a new expression's first digit d sets `result` = d.
- Overflow wraps silently modulo 2^W in both the multiply and the add; it is not an error.
- Multiply by `0` is legal and yields 0 for that term.

## Timing
- Latency: one cycle. Outputs reflect character k after the rising edge that samples it.
- `done` is high for exactly one cycle per EQ consumed, then deasserts; back-to-back EQ in S_NUM after a restart is an error, with no done.
- A character may be consumed every cycle; there is no backpressure output.
- `clr` low mid-expression discards all partial state; the first character after `clr` returns high is treated as the start of a new expression.
- `clr` low in the same cycle as `in_valid` with EQ: reset wins and `done` stays 0.

## Test plan
- "1+2*3=" consecutive cycles: `result` = 1,1,3,3,7,7; `ok` = 1,0,1,0,1,0; `done` = 1 only on the cycle after `=`; `err` = 0 throughout.
- "1++2=": `err` = 1 from the second `+`, `ok` = 0; the `=` gives `done` = 1 with `err` = 1; the next cycle gives `err` = 0. Then "5=" gives `result` = 5 and `done` = 1.
- "1+2", then `clr` = 0 for one cycle with `in` = "3", then "4=": after reset `result` = 0, `ok` = 0; final `result` = 4 with `done` = 1.
- "9*", then `in_valid` = 0 for 3 cycles with `in` = "+", then "9=": outputs frozen while invalid; final `result` = 81.
- W = 8, "9*9*9=": `result` = 217 (729 mod 256) and `done` = 1. Then "0*7+3=" gives `result` = 3.
- Leading "=" and "a": each sets `err` = 1; `=` from S_ERR gives `done` = 1. "=" as the first character after reset gives `err` = 1 with no `done`.
